// File: rtl/cam_pkg.sv
// Shared types and default sizes for the CAM controller and its bench.
package cam_pkg;

    localparam int CAM_WIDTH_DEF = 32;
    localparam int CAM_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        OP_SEARCH = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_FLUSH  = 2'b11
    } cam_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOOKUP = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_RESP   = 2'b11
    } ctrl_state_e;

endpackage

// File: rtl/cam_ctrl_if.sv
// Request/response handshake bundle between a requester and cam_ctrl.
interface cam_ctrl_if #(
    parameter int CAM_WIDTH = 32,
    parameter int CAM_DEPTH = 16
);
    localparam int IW = $clog2(CAM_DEPTH);

    logic                 req_vld;
    logic                 req_rdy;
    logic [1:0]           req_op;
    logic [CAM_WIDTH-1:0] req_data;
    logic                 resp_vld;
    logic                 resp_rdy;
    logic                 resp_hit;
    logic [IW-1:0]        resp_idx;
    logic                 resp_evict;

    modport master (
        output req_vld, req_op, req_data, resp_rdy,
        input  req_rdy, resp_vld, resp_hit, resp_idx, resp_evict
    );

    modport slave (
        input  req_vld, req_op, req_data, resp_rdy,
        output req_rdy, resp_vld, resp_hit, resp_idx, resp_evict
    );

endinterface

// File: rtl/cam_lsb_enc.sv
// Lowest-set-bit encoder: index of the least significant 1 and an any-bit flag.
module cam_lsb_enc #(
    parameter  int N  = 16,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IW'(i);
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/cam_ctrl.sv
// CAM controller: search/insert/delete/flush sequencing, occupancy tracking
// and round-robin eviction when the CAM is full.
module cam_ctrl
    import cam_pkg::*;
#(
    parameter  int CAM_WIDTH = CAM_WIDTH_DEF,
    parameter  int CAM_DEPTH = CAM_DEPTH_DEF,
    localparam int IW        = $clog2(CAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cam_ctrl_if.slave            bus,
    output logic                 cam_data_we,
    output logic [IW-1:0]        cam_data_idx,
    output logic [CAM_WIDTH-1:0] cam_data_i,
    output logic                 cam_data_vld,
    input  logic [CAM_DEPTH-1:0] cam_camml,
    output logic [IW:0]          occ_cnt,
    output logic                 full
);

    localparam logic [IW:0]   DEPTH_CNT = (IW + 1)'(CAM_DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(CAM_DEPTH - 1);

    ctrl_state_e          state_q, state_d;
    cam_op_e              op_q, op_d;
    logic [CAM_WIDTH-1:0] key_q;
    logic [CAM_DEPTH-1:0] occ_q, occ_d;
    logic [IW:0]          occ_cnt_q, occ_cnt_d;
    logic [IW-1:0]        victim_q, victim_d;
    logic [IW-1:0]        flush_cnt_q, flush_cnt_d;
    logic                 resp_hit_q, resp_hit_d;
    logic [IW-1:0]        resp_idx_q, resp_idx_d;
    logic                 resp_evict_q, resp_evict_d;

    logic                 req_rdy;
    logic                 accept;
    logic [IW-1:0]        match_idx, free_idx;
    logic                 match_any, free_any;

    // Lookup-cycle decision
    logic                 lk_we, lk_vld, lk_hit, lk_evict, lk_fill, lk_drop;
    logic [IW-1:0]        lk_idx;

    assign accept = req_rdy && bus.req_vld;

    cam_lsb_enc #(.N(CAM_DEPTH)) u_match_enc (
        .vec_i (cam_camml),
        .idx_o (match_idx),
        .any_o (match_any)
    );

    cam_lsb_enc #(.N(CAM_DEPTH)) u_free_enc (
        .vec_i (~occ_q),
        .idx_o (free_idx),
        .any_o (free_any)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = (cam_op_e'(bus.req_op) == OP_FLUSH) ? ST_FLUSH : ST_LOOKUP;
            ST_LOOKUP: state_d = ST_RESP;
            ST_FLUSH:  if (flush_cnt_q == LAST_IDX) state_d = ST_RESP;
            ST_RESP:   if (bus.resp_rdy) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Resolve what the single lookup cycle does from the match and free lines.
    always_comb begin
        lk_we    = 1'b0;
        lk_vld   = 1'b0;
        lk_idx   = match_idx;
        lk_hit   = match_any;
        lk_evict = 1'b0;
        lk_fill  = 1'b0;
        lk_drop  = 1'b0;
        unique case (op_q)
            OP_INSERT: begin
                if (!match_any) begin
                    lk_we  = 1'b1;
                    lk_vld = 1'b1;
                    if (free_any) begin
                        lk_idx  = free_idx;
                        lk_fill = 1'b1;
                    end else begin
                        lk_idx   = victim_q;
                        lk_evict = 1'b1;
                    end
                end
            end
            OP_DELETE: begin
                if (match_any) begin
                    lk_we   = 1'b1;
                    lk_drop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FSM outputs: handshakes and the CAM write port.
    always_comb begin
        req_rdy      = (state_q == ST_IDLE);
        bus.resp_vld = (state_q == ST_RESP);
        cam_data_i   = key_q;
        cam_data_we  = 1'b0;
        cam_data_idx = '0;
        cam_data_vld = 1'b0;
        unique case (state_q)
            ST_LOOKUP: begin
                cam_data_we  = lk_we;
                cam_data_idx = lk_idx;
                cam_data_vld = lk_vld;
            end
            ST_FLUSH: begin
                cam_data_we  = 1'b1;
                cam_data_idx = flush_cnt_q;
                cam_data_vld = 1'b0;
            end
            default: ;
        endcase
    end

    // Occupancy, eviction pointer, flush counter and response next-state.
    always_comb begin
        op_d         = op_q;
        occ_d        = occ_q;
        occ_cnt_d    = occ_cnt_q;
        victim_d     = victim_q;
        flush_cnt_d  = flush_cnt_q;
        resp_hit_d   = resp_hit_q;
        resp_idx_d   = resp_idx_q;
        resp_evict_d = resp_evict_q;
        if (accept) op_d = cam_op_e'(bus.req_op);
        unique case (state_q)
            ST_LOOKUP: begin
                resp_hit_d   = lk_hit;
                resp_idx_d   = lk_idx;
                resp_evict_d = lk_evict;
                if (lk_we) occ_d[lk_idx] = lk_vld;
                if (lk_fill && occ_cnt_q != DEPTH_CNT) occ_cnt_d = occ_cnt_q + 1'b1;
                if (lk_drop && occ_cnt_q != '0)        occ_cnt_d = occ_cnt_q - 1'b1;
                if (lk_evict) victim_d = victim_q + 1'b1;
            end
            ST_FLUSH: begin
                occ_d[flush_cnt_q] = 1'b0;
                // Counter wraps back to 0 after the last index, ready for the next flush.
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == LAST_IDX) begin
                    occ_d        = '0;
                    occ_cnt_d    = '0;
                    victim_d     = '0;
                    resp_hit_d   = 1'b0;
                    resp_idx_d   = '0;
                    resp_evict_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= OP_SEARCH;
            occ_q        <= '0;
            occ_cnt_q    <= '0;
            victim_q     <= '0;
            flush_cnt_q  <= '0;
            resp_hit_q   <= 1'b0;
            resp_idx_q   <= '0;
            resp_evict_q <= 1'b0;
        end else begin
            op_q         <= op_d;
            occ_q        <= occ_d;
            occ_cnt_q    <= occ_cnt_d;
            victim_q     <= victim_d;
            flush_cnt_q  <= flush_cnt_d;
            resp_hit_q   <= resp_hit_d;
            resp_idx_q   <= resp_idx_d;
            resp_evict_q <= resp_evict_d;
        end
    end

    // Latched search key; pure data, only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (accept) key_q <= bus.req_data;
    end

    assign bus.req_rdy    = req_rdy;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.resp_idx   = resp_idx_q;
    assign bus.resp_evict = resp_evict_q;
    assign occ_cnt        = occ_cnt_q;
    assign full           = (occ_cnt_q == DEPTH_CNT);

endmodule

// File: tb/tb_cam_ctrl.sv
// Scoreboard bench for cam_ctrl with a behavioural CAM table model.
module tb_cam_ctrl;
    import cam_pkg::*;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int IW = 2;

    typedef struct {
        bit hit;
        int idx;
        bit evict;
        int lat;
        int occ;
        int acc;
    } rsp_t;

    typedef struct {
        int         idx;
        bit         vld;
        logic [W-1:0] key;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cam_ctrl_if #(.CAM_WIDTH(W), .CAM_DEPTH(D)) bus ();

    logic          cam_data_we;
    logic [IW-1:0] cam_data_idx;
    logic [W-1:0]  cam_data_i;
    logic          cam_data_vld;
    logic [D-1:0]  cam_camml;
    logic [IW:0]   occ_cnt;
    logic          full;

    cam_ctrl #(.CAM_WIDTH(W), .CAM_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .cam_data_we  (cam_data_we),
        .cam_data_idx (cam_data_idx),
        .cam_data_i   (cam_data_i),
        .cam_data_vld (cam_data_vld),
        .cam_camml    (cam_camml),
        .occ_cnt      (occ_cnt),
        .full         (full)
    );

    // CAM storage attached to the controller's write/compare port.
    logic [W-1:0] mem_key [D];
    logic         mem_v   [D];

    always_comb begin
        cam_camml = '0;
        for (int i = 0; i < D; i++) cam_camml[i] = mem_v[i] && (mem_key[i] == cam_data_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) mem_v[i] <= 1'b0;
        end else if (cam_data_we) begin
            mem_v[cam_data_idx] <= cam_data_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (cam_data_we) mem_key[cam_data_idx] <= cam_data_i;
    end

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;
    int   done = 0;
    int   hold_req = 0;
    bit   in_rst = 1'b1;
    bit   in_resp = 1'b0;
    bit   hs_next = 1'b0;
    rsp_t exp_q[$];
    wr_t  wr_q[$];

    // Reference table: plain array of keys and valid flags.
    logic [W-1:0] m_key [D];
    bit           m_v   [D];
    int           m_vict = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", nm);
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_v[i] = 1'b0;
        m_vict = 0;
    endtask

    function automatic int m_find(input logic [W-1:0] k);
        for (int i = 0; i < D; i++) if (m_v[i] && m_key[i] == k) return i;
        return -1;
    endfunction

    task automatic model_op(input logic [1:0] op, input logic [W-1:0] k, input int acc);
        rsp_t r;
        wr_t  w;
        int   f;
        int   slot;
        f       = m_find(k);
        r.hit   = 1'b0;
        r.idx   = 0;
        r.evict = 1'b0;
        r.lat   = 2;
        r.acc   = acc;
        case (op)
            2'b00: begin
                r.hit = (f >= 0);
                r.idx = (f >= 0) ? f : 0;
            end
            2'b01: begin
                if (f >= 0) begin
                    r.hit = 1'b1;
                    r.idx = f;
                end else begin
                    slot = -1;
                    for (int i = D - 1; i >= 0; i--) if (!m_v[i]) slot = i;
                    if (slot < 0) begin
                        slot    = m_vict;
                        r.evict = 1'b1;
                        m_vict  = (m_vict + 1) % D;
                    end
                    m_key[slot] = k;
                    m_v[slot]   = 1'b1;
                    r.idx       = slot;
                    w.idx = slot; w.vld = 1'b1; w.key = k;
                    wr_q.push_back(w);
                end
            end
            2'b10: begin
                if (f >= 0) begin
                    r.hit   = 1'b1;
                    r.idx   = f;
                    m_v[f]  = 1'b0;
                    w.idx = f; w.vld = 1'b0; w.key = k;
                    wr_q.push_back(w);
                end
            end
            default: begin
                for (int i = 0; i < D; i++) begin
                    w.idx = i; w.vld = 1'b0; w.key = '0;
                    wr_q.push_back(w);
                end
                model_reset();
                r.lat = D + 1;
            end
        endcase
        r.occ = 0;
        for (int i = 0; i < D; i++) if (m_v[i]) r.occ++;
        exp_q.push_back(r);
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] k);
        int n;
        @(negedge clk);
        bus.req_vld  = 1'b1;
        bus.req_op   = op;
        bus.req_data = k;
        n = 0;
        while (!bus.req_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_rdy) begin
            fail("accept_timeout");
            bus.req_vld = 1'b0;
        end else begin
            model_op(op, k, cyc);
            @(posedge clk);
            accepted++;
            #1 bus.req_vld = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (accepted != done && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (accepted != done) fail("idle_timeout");
    endtask

    // Response monitor: pops the scoreboard, checks stability while stalled,
    // and drives resp_rdy with random back-pressure.
    initial begin
        rsp_t        r;
        logic        cap_hit, cap_evict;
        logic [IW-1:0] cap_idx;
        int          hold;
        bit          rdy;
        hold = 0;
        bus.resp_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (!in_rst) begin
                if (hs_next) begin
                    hs_next = 1'b0;
                    in_resp = 1'b0;
                    done++;
                    chk("resp_vld_after_handshake", 64'(bus.resp_vld), 64'(0));
                end
                chk("req_rdy_when_idle", 64'(bus.req_rdy), 64'(accepted == done));
                if (bus.resp_vld) begin
                    if (!in_resp) begin
                        in_resp = 1'b1;
                        cap_hit = bus.resp_hit;
                        cap_idx = bus.resp_idx;
                        cap_evict = bus.resp_evict;
                        hold = hold_req;
                        hold_req = 0;
                        if (exp_q.size() == 0) begin
                            fail("unexpected_response");
                        end else begin
                            r = exp_q.pop_front();
                            chk("resp_hit", 64'(bus.resp_hit), 64'(r.hit));
                            chk("resp_idx", 64'(bus.resp_idx), 64'(r.idx));
                            chk("resp_evict", 64'(bus.resp_evict), 64'(r.evict));
                            chk("latency", 64'(cyc - r.acc), 64'(r.lat));
                            chk("occ_cnt", 64'(occ_cnt), 64'(r.occ));
                            chk("full", 64'(full), 64'(r.occ == D));
                            chk("writes_pending", 64'(wr_q.size()), 64'(0));
                        end
                    end else begin
                        chk("hold_hit", 64'(bus.resp_hit), 64'(cap_hit));
                        chk("hold_idx", 64'(bus.resp_idx), 64'(cap_idx));
                        chk("hold_evict", 64'(bus.resp_evict), 64'(cap_evict));
                    end
                end
                if (bus.resp_vld && hold > 0) begin
                    rdy = 1'b0;
                    hold--;
                end else begin
                    rdy = ($urandom_range(0, 3) != 0);
                end
                if (bus.resp_vld && rdy) hs_next = 1'b1;
                bus.resp_rdy = rdy;
            end
        end
    end

    // Write monitor: every CAM write must be one the model predicted, in order.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (!in_rst && cam_data_we) begin
                if (wr_q.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_idx", 64'(cam_data_idx), 64'(w.idx));
                    chk("wr_vld", 64'(cam_data_vld), 64'(w.vld));
                    if (w.vld) chk("wr_key", 64'(cam_data_i), 64'(w.key));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          op_r;
        logic [1:0]  op;
        bus.req_vld  = 1'b0;
        bus.req_op   = 2'b00;
        bus.req_data = '0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_vld", 64'(bus.resp_vld), 64'(0));
        chk("rst_req_rdy", 64'(bus.req_rdy), 64'(1));
        chk("rst_occ_cnt", 64'(occ_cnt), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_we", 64'(cam_data_we), 64'(0));
        chk("rst_hit", 64'(bus.resp_hit), 64'(0));
        chk("rst_idx", 64'(bus.resp_idx), 64'(0));
        chk("rst_evict", 64'(bus.resp_evict), 64'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 in_rst = 1'b0;

        // Insert/search, repeated insert
        issue(2'b01, 32'hA5);
        issue(2'b00, 32'hA5);
        issue(2'b01, 32'hA5);
        // Fill, then evict round-robin
        issue(2'b11, 32'h0);
        for (int k = 1; k <= 6; k++) issue(2'b01, W'(k));
        // Delete/reinsert, absent delete
        issue(2'b11, 32'h0);
        for (int k = 1; k <= 4; k++) issue(2'b01, W'(k));
        issue(2'b10, 32'd2);
        issue(2'b01, 32'd7);
        issue(2'b10, 32'd99);
        issue(2'b00, 32'd7);
        // Long back-pressure with a queued request behind it
        wait_idle();
        hold_req = 5;
        issue(2'b00, 32'd3);
        issue(2'b00, 32'd4);
        // Flush with three entries
        wait_idle();
        issue(2'b11, 32'h0);
        for (int k = 1; k <= 3; k++) issue(2'b01, W'(k + 16));
        issue(2'b11, 32'h0);
        issue(2'b00, 32'd17);
        // Reset in the middle of a flush
        wait_idle();
        for (int k = 1; k <= 3; k++) issue(2'b01, W'(k + 32));
        wait_idle();
        issue(2'b11, 32'h0);
        @(posedge clk);
        #3;
        in_rst = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("flush_rst_resp_vld", 64'(bus.resp_vld), 64'(0));
        chk("flush_rst_req_rdy", 64'(bus.req_rdy), 64'(1));
        chk("flush_rst_we", 64'(cam_data_we), 64'(0));
        chk("flush_rst_occ_cnt", 64'(occ_cnt), 64'(0));
        chk("flush_rst_full", 64'(full), 64'(0));
        exp_q.delete();
        wr_q.delete();
        model_reset();
        accepted = 0;
        done     = 0;
        in_resp  = 1'b0;
        hs_next  = 1'b0;
        hold_req = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 in_rst = 1'b0;
        issue(2'b00, 32'd33);

        // Randomized traffic over a small key space so hits are frequent.
        for (int t = 0; t < 300; t++) begin
            op_r = int'($urandom_range(0, 99));
            if (op_r < 35)      op = 2'b00;
            else if (op_r < 70) op = 2'b01;
            else if (op_r < 95) op = 2'b10;
            else                op = 2'b11;
            issue(op, W'($urandom_range(1, 7)));
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_ctrl.md
CAM_CTRL -- requirements
Module: cam_ctrl

Interface
REQ-001 Parameter CAM_WIDTH, default 32, key width in bits.
REQ-002 Parameter CAM_DEPTH, default 16, number of CAM entries; must be a power of two and at least 2; IW = $clog2(CAM_DEPTH).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_vld  in  1  request valid.
REQ-006 req_rdy  out  1  request ready.
REQ-007 req_op  in  2  opcode: 00 SEARCH, 01 INSERT, 10 DELETE, 11 FLUSH.
REQ-008 req_data  in  CAM_WIDTH  request key; ignored for FLUSH.
REQ-009 resp_vld  out  1  response valid.
REQ-010 resp_rdy  in  1  response ready.
REQ-011 resp_hit  out  1  the key matched a valid entry.
REQ-012 resp_idx  out  IW  entry index that was matched, written or evicted.
REQ-013 resp_evict  out  1  an INSERT overwrote a valid entry.
REQ-014 cam_data_we, cam_data_idx (IW), cam_data_i (CAM_WIDTH), cam_data_vld  out  CAM write/compare port.
REQ-015 cam_camml  in  CAM_DEPTH  one-hot-or-zero match line from the CAM; combinational in cam_data_i.
REQ-016 occ_cnt  out  IW+1  number of occupied entries; full  out  1  asserted when occ_cnt == CAM_DEPTH.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOOKUP, FLUSH and RESP.
REQ-018 req_rdy SHALL be 1 only in IDLE; a request is accepted when req_vld && req_rdy, and the op and data are latched.
REQ-019 Accepting SEARCH, INSERT or DELETE SHALL move IDLE->LOOKUP; accepting FLUSH SHALL move IDLE->FLUSH.
REQ-020 In LOOKUP, cam_data_i SHALL equal the latched key; the match index is the lowest set bit of cam_camml, and a hit is any bit set.
REQ-021 SEARCH: there SHALL be no write; the response carries the hit flag and the match index.
REQ-022 INSERT hit: there SHALL be no write; resp_hit=1 and resp_idx is the match index.
REQ-023 INSERT miss, not full: the controller SHALL write the lowest free entry in the same LOOKUP cycle (we=1, vld=1); it sets the occupancy bit; resp_hit=0 and resp_idx is the written index.
REQ-024 INSERT miss, full: the controller SHALL write at victim_ptr; resp_evict=1; victim_ptr advances by 1 and wraps from CAM_DEPTH-1 to 0.
REQ-025 DELETE hit: the controller SHALL write the match index with vld=0; it clears the occupancy bit; resp_hit=1. DELETE miss: no write, resp_hit=0.
REQ-026 LOOKUP SHALL last exactly one cycle and then go to RESP.
REQ-027 FLUSH SHALL write vld=0 to indices 0..CAM_DEPTH-1, one per cycle, with an IW-bit counter; after the last index it goes to RESP.
REQ-028 After a FLUSH, occupancy, occ_cnt and victim_ptr SHALL all be 0; the response has resp_hit=0 and resp_idx=0.
REQ-029 RESP SHALL hold resp_vld and all response fields stable until resp_rdy; on the handshake it goes to IDLE.
REQ-030 Latency from acceptance to resp_vld SHALL be 2 cycles for SEARCH/INSERT/DELETE and CAM_DEPTH+1 cycles for FLUSH.
REQ-031 cam_data_we SHALL be 0 in all states except the LOOKUP write cases and FLUSH.
REQ-032 The occupancy vector SHALL be updated in the same cycle as the CAM write.
REQ-033 occ_cnt SHALL be registered and change in the cycle after the write; it never exceeds CAM_DEPTH or underflows.
REQ-034 A request arriving while busy SHALL be stalled, not dropped.

Reset
REQ-035 While rst_n=0, the block SHALL hold: state IDLE, occupancy 0, occ_cnt 0, full 0, victim_ptr 0, flush counter 0, resp_vld 0, resp fields 0, cam_data_we 0.
REQ-036 A reset in any state SHALL abort the operation with no response.
REQ-037 Integration SHALL reset the CAM in the same event so that it mirrors the occupancy state.

Structure
REQ-038 cam_pkg SHALL hold the cam_op_e enum, the ctrl_state_e enum and the CAM_WIDTH/CAM_DEPTH defaults.
REQ-039 One sub-module, cam_lsb_enc, SHALL be a parameterised lowest-set-bit encoder with index and any outputs.
REQ-040 cam_lsb_enc SHALL be instantiated twice: once on cam_camml and once on the inverted occupancy vector.

Verification
REQ-041 With CAM_DEPTH=4: INSERT 0xA5 -> resp at +2 cycles with hit=0, idx=0; occ_cnt=1; SEARCH 0xA5 -> hit=1, idx=0.
REQ-042 INSERT 0xA5 twice -> second response hit=1, idx=0, no cam_data_we pulse, occ_cnt stays 1.
REQ-043 INSERT keys 1..4, then key 5 -> evict=1, idx=0; then key 6 -> idx=1; occ_cnt stays 4 and full=1.
REQ-044 DELETE key 2 (idx 1), then INSERT 7 -> 7 is written at idx 1; DELETE of an absent key -> hit=0 with no write.
REQ-045 Hold resp_rdy=0 for 5 cycles during RESP -> fields stay stable, req_rdy=0, and a queued req_vld is accepted the cycle after the handshake.
REQ-046 FLUSH with 3 entries -> 4 write pulses with vld=0 to idx 0..3, resp at +5 cycles, occ_cnt=0; rst_n low during FLUSH -> resp_vld=0 and IDLE immediately.
